multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Control state machine that sequences a shared-resource, multi-cycle version of the CPU datapath. One unified memory port serves both instruction fetch and data access, and one ALU serves PC increment, branch target and execution. The block decodes the latched instruction's opcode and funct fields and steps the datapath through fetch, decode, execute, memory and writeback. It stalls on a memory ready handshake and counts retired instructions. It sits beside the Reg_File, ALU, ALU_Ctrl and memory, replacing the single-cycle Decoder.

## Interface
- Parameters
  - CNT_W, 32, width of the retired-instruction counter.
- Ports
  - clk_i  in  1  clock; all state changes on the rising edge.
  - rst_i  in  1  asynchronous, active-low reset.
  - opcode_i  in  6  instruction register bits [31:26].
  - funct_i  in  6  instruction register bits [5:0].
  - mem_ready_i  in  1  memory has completed the current read or write this cycle.
  - branch_taken_i  in  1  datapath compare result for the selected branch condition.
  - pc_write_o  out  1  unconditional PC load.
  - pc_write_cond_o  out  1  PC load gated by branch_taken_i, combined in the datapath.
  - pc_source_o  out  2  PC source: 0 ALU result, 1 ALUOut, 2 jump target {PC[31:28], imm26, 2'b00}, 3 rs.
  - ior_o  out  1  memory address source: 0 PC, 1 ALUOut.
  - mem_read_o  out  1  memory read request.
  - mem_write_o  out  1  memory write request.
  - ir_write_o  out  1  instruction register load.
  - reg_write_o  out  1  register file write.
  - reg_dst_o  out  2  destination register: 0 rt, 1 rd, 2 r31.
  - mem_to_reg_o  out  2  write data: 0 ALUOut, 1 MDR, 2 PC.
  - alu_src_a_o  out  1  ALU A operand: 0 PC, 1 rs.
  - alu_src_b_o  out  2  ALU B operand: 0 rt, 1 constant 4, 2 extended immediate, 3 extended immediate << 2.
  - alu_op_o  out  4  operation code to ALU_Ctrl.
  - zero_ext_o  out  1  zero-extend the immediate (sltiu, ori).
  - branch_cond_o  out  2  branch condition: 0 eq, 1 ne, 2 le, 3 ltz.
  - retired_o  out  CNT_W  count of completed instructions.
  - trap_o  out  1  sticky illegal-opcode flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, TRAP. Reset state is FETCH.
- Moore outputs: decoded from the registered state plus the registered opcode/funct. Any output not listed for a state is 0.
- FETCH: mem_read, ior=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - ir_write and pc_write are asserted only when mem_ready_i=1; the FSM then moves to DECODE, otherwise it holds in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD, precomputing the branch target into ALUOut. Dispatch on opcode:
  - 35 (lw) and 43 (sw) go to MEMADR.
  - 0 with funct 8 (jr) goes to JUMP.
  - 0 otherwise goes to EXEC.
  - 8, 9, 13, 15 go to EXEC.
  - 1, 4, 5, 6 go to BRANCH.
  - 2 and 3 go to JUMP.
  - Anything else goes to TRAP.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read, ior=1. Holds until mem_ready_i, then goes to MEMWB.
- MEMWB: reg_write, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: mem_write, ior=1. Holds until mem_ready_i, then goes to FETCH.
- EXEC: alu_src_a=1. Next state ALUWB.
  - R-type: alu_src_b=0, alu_op=FUNCT.
  - I-type: alu_src_b=2, alu_op = ADD (opcode 8), SLTU (9), OR (13) or LUI (15).
  - zero_ext=1 for opcodes 9 and 13.
- ALUWB: reg_write, mem_to_reg=0, reg_dst=1 for R-type, 0 for I-type. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond, pc_source=1. branch_cond = 3 (opcode 1), 0 (opcode 4), 1 (opcode 5), 2 (opcode 6). Next state FETCH.
- JUMP: pc_write. Next state FETCH.
  - pc_source=3 for jr, 2 for j and jal.
  - jal also asserts reg_write, reg_dst=2, mem_to_reg=2; PC already holds PC+4.
- retired_o increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP. It wraps modulo 2^CNT_W.
- TRAP: all strobes 0, trap_o=1. Exit only by reset.

## Timing
- Reset (rst_i=0, asynchronous):
  - state is FETCH, retired_o=0, trap_o=0.
  - All strobes deasserted while rst_i is low, including mid-handshake. A pending memory access is abandoned.
- Zero-wait latencies: R-type and I-type ALU 4 cycles; lw 5; sw 4; branch 3; j, jal and jr 3. Each mem_ready_i-low cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- Request hold: mem_read_o and mem_write_o stay asserted, with a stable ior_o, every cycle until mem_ready_i is sampled high. mem_ready_i is ignored in all other states.
- opcode_i and funct_i are sampled only in DECODE and held internally for the rest of the instruction. IR changes after FETCH must not alter control.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state enum;
  - ALU op codes: ADD=0, SUB=1, FUNCT=2, OR=3, SLTU=4, LUI=5;
  - opcode constants;
  - the encodings for pc_source, alu_src_b, reg_dst and mem_to_reg.
- One sub-module, mc_ctrl_decode: a combinational map from state plus latched opcode/funct to the output bundle. The FSM register and retired counter live in the top.

## Test plan
- Reset mid-fetch: rst_i low during FETCH with mem_read_o=1 -> all strobes 0 immediately, retired_o=0; after release, FETCH with PC-source strobes restored.
- add (opcode 0, funct 32), mem_ready_i always 1 -> state sequence FETCH, DECODE, EXEC, ALUWB; reg_write_o=1 with reg_dst_o=1 in cycle 4; retired_o goes 0 to 1.
- lw (35) with mem_ready_i low for 2 cycles in MEMRD -> mem_read_o=1 and ior_o=1 held 3 cycles; MEMWB writes with mem_to_reg_o=1; 7 cycles total.
- beq (4) with branch_taken_i=0, then bne (5) with branch_taken_i=1 -> pc_write_cond_o=1, branch_cond_o 0 then 1, pc_source_o=1; 3 cycles each.
- jal (3) then jr (0, funct 8) -> JUMP state: jal gives pc_source_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2; jr gives pc_source_o=3, reg_write_o=0.
- Opcode 63 -> TRAP after DECODE; trap_o=1, all strobes 0 for 20 cycles, retired_o unchanged; cleared only by reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types, encodings and opcode dispatch for the multi-cycle controller
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_FUNCT = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_LUI   = 4'd5;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BLTZ  = 6'd1;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_BLEZ  = 6'd6;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTIU = 6'd9;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] FN_JR    = 6'd8;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] RDST_RT = 2'd0;
   localparam logic [1:0] RDST_RD = 2'd1;
   localparam logic [1:0] RDST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       ior;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       zero_ext;
      logic [1:0] branch_cond;
      logic       trap;
   } ctrl_t;

   function automatic state_t dispatch(input logic [5:0] opcode, input logic [5:0] funct);
      case (opcode)
         OP_LW, OP_SW:                       dispatch = S_MEMADR;
         OP_RTYPE:                           dispatch = (funct == FN_JR) ? S_JUMP : S_EXEC;
         OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:  dispatch = S_EXEC;
         OP_BLTZ, OP_BEQ, OP_BNE, OP_BLEZ:   dispatch = S_BRANCH;
         OP_J, OP_JAL:                       dispatch = S_JUMP;
         default:                            dispatch = S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - controller <-> datapath signal bundle
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32);
   logic [5:0]       opcode_i;
   logic [5:0]       funct_i;
   logic             mem_ready_i;
   logic             branch_taken_i;
   logic             pc_write_o;
   logic             pc_write_cond_o;
   logic [1:0]       pc_source_o;
   logic             ior_o;
   logic             mem_read_o;
   logic             mem_write_o;
   logic             ir_write_o;
   logic             reg_write_o;
   logic [1:0]       reg_dst_o;
   logic [1:0]       mem_to_reg_o;
   logic             alu_src_a_o;
   logic [1:0]       alu_src_b_o;
   logic [3:0]       alu_op_o;
   logic             zero_ext_o;
   logic [1:0]       branch_cond_o;
   logic [CNT_W-1:0] retired_o;
   logic             trap_o;

   modport master (
      input  opcode_i, funct_i, mem_ready_i, branch_taken_i,
      output pc_write_o, pc_write_cond_o, pc_source_o, ior_o, mem_read_o, mem_write_o,
             ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, zero_ext_o, branch_cond_o, retired_o, trap_o
   );

   modport slave (
      output opcode_i, funct_i, mem_ready_i, branch_taken_i,
      input  pc_write_o, pc_write_cond_o, pc_source_o, ior_o, mem_read_o, mem_write_o,
             ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, zero_ext_o, branch_cond_o, retired_o, trap_o
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - state plus latched opcode/funct to control bundle
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctl
);

   always_comb begin
      o_ctl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctl.mem_read  = 1'b1;
            o_ctl.alu_src_b = SRCB_FOUR;
            o_ctl.alu_op    = ALU_ADD;
            o_ctl.pc_source = PCSRC_ALU;
            o_ctl.ir_write  = i_mem_ready;
            o_ctl.pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            o_ctl.alu_src_b = SRCB_IMM_SH;
            o_ctl.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            o_ctl.alu_src_a = 1'b1;
            o_ctl.alu_src_b = SRCB_IMM;
            o_ctl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            o_ctl.mem_read = 1'b1;
            o_ctl.ior      = 1'b1;
         end
         S_MEMWB: begin
            o_ctl.reg_write  = 1'b1;
            o_ctl.reg_dst    = RDST_RT;
            o_ctl.mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            o_ctl.mem_write = 1'b1;
            o_ctl.ior       = 1'b1;
         end
         S_EXEC: begin
            o_ctl.alu_src_a = 1'b1;
            if (i_opcode == OP_RTYPE) begin
               o_ctl.alu_src_b = SRCB_RT;
               o_ctl.alu_op    = ALU_FUNCT;
            end else begin
               o_ctl.alu_src_b = SRCB_IMM;
               case (i_opcode)
                  OP_SLTIU: o_ctl.alu_op = ALU_SLTU;
                  OP_ORI:   o_ctl.alu_op = ALU_OR;
                  OP_LUI:   o_ctl.alu_op = ALU_LUI;
                  default:  o_ctl.alu_op = ALU_ADD;
               endcase
            end
            o_ctl.zero_ext = (i_opcode == OP_SLTIU) || (i_opcode == OP_ORI);
         end
         S_ALUWB: begin
            o_ctl.reg_write  = 1'b1;
            o_ctl.mem_to_reg = M2R_ALUOUT;
            o_ctl.reg_dst    = (i_opcode == OP_RTYPE) ? RDST_RD : RDST_RT;
         end
         S_BRANCH: begin
            o_ctl.alu_src_a     = 1'b1;
            o_ctl.alu_src_b     = SRCB_RT;
            o_ctl.alu_op        = ALU_SUB;
            o_ctl.pc_write_cond = 1'b1;
            o_ctl.pc_source     = PCSRC_ALUOUT;
            case (i_opcode)
               OP_BLTZ: o_ctl.branch_cond = 2'd3;
               OP_BNE:  o_ctl.branch_cond = 2'd1;
               OP_BLEZ: o_ctl.branch_cond = 2'd2;
               default: o_ctl.branch_cond = 2'd0;
            endcase
         end
         S_JUMP: begin
            o_ctl.pc_write  = 1'b1;
            o_ctl.pc_source = (i_opcode == OP_RTYPE && i_funct == FN_JR) ? PCSRC_RS : PCSRC_JUMP;
            // Link: PC was already advanced to PC+4 during FETCH
            if (i_opcode == OP_JAL) begin
               o_ctl.reg_write  = 1'b1;
               o_ctl.reg_dst    = RDST_RA;
               o_ctl.mem_to_reg = M2R_PC;
            end
         end
         S_TRAP: o_ctl.trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle CPU control FSM with retired-instruction counter
module multi_cycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   multi_cycle_ctrl_if.master  bus
);

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_opcode;
   logic [5:0]       r_funct;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;
   ctrl_t            w_dec;
   ctrl_t            w_ctl;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_FETCH:  if (bus.mem_ready_i) w_next = S_DECODE;
         S_DECODE: w_next = dispatch(bus.opcode_i, bus.funct_i);
         S_MEMADR: w_next = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.mem_ready_i) w_next = S_MEMWB;
         S_MEMWR: begin
            if (bus.mem_ready_i) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end
         S_EXEC:   w_next = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_FETCH;
      endcase
   end

   // IR may change after FETCH; control uses only the copy taken in DECODE
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_opcode <= '0;
         r_funct  <= '0;
      end else if (r_state == S_DECODE) begin
         r_opcode <= bus.opcode_i;
         r_funct  <= bus.funct_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)        r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + 1'b1;
   end

   mc_ctrl_decode u_decode (
      .i_state     (r_state),
      .i_opcode    (r_opcode),
      .i_funct     (r_funct),
      .i_mem_ready (bus.mem_ready_i),
      .o_ctl       (w_dec)
   );

   // Reset forces strobes low at once, abandoning any pending memory access
   assign w_ctl = rst_i ? w_dec : '0;

   assign bus.pc_write_o      = w_ctl.pc_write;
   assign bus.pc_write_cond_o = w_ctl.pc_write_cond;
   assign bus.pc_source_o     = w_ctl.pc_source;
   assign bus.ior_o           = w_ctl.ior;
   assign bus.mem_read_o      = w_ctl.mem_read;
   assign bus.mem_write_o     = w_ctl.mem_write;
   assign bus.ir_write_o      = w_ctl.ir_write;
   assign bus.reg_write_o     = w_ctl.reg_write;
   assign bus.reg_dst_o       = w_ctl.reg_dst;
   assign bus.mem_to_reg_o    = w_ctl.mem_to_reg;
   assign bus.alu_src_a_o     = w_ctl.alu_src_a;
   assign bus.alu_src_b_o     = w_ctl.alu_src_b;
   assign bus.alu_op_o        = w_ctl.alu_op;
   assign bus.zero_ext_o      = w_ctl.zero_ext;
   assign bus.branch_cond_o   = w_ctl.branch_cond;
   assign bus.trap_o          = w_ctl.trap;
   assign bus.retired_o       = r_retired;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

   typedef struct packed {
      logic       pw;
      logic       pwc;
      logic [1:0] psrc;
      logic       ior;
      logic       mr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rdst;
      logic [1:0] m2r;
      logic       sa;
      logic [1:0] sb;
      logic [3:0] op;
      logic       zx;
      logic [1:0] bc;
   } tb_ctl_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   multi_cycle_ctrl_if #(.CNT_W(32)) bus ();

   multi_cycle_ctrl #(.CNT_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.master)
   );

   function automatic tb_ctl_t obs();
      tb_ctl_t o;
      o.pw   = bus.pc_write_o;
      o.pwc  = bus.pc_write_cond_o;
      o.psrc = bus.pc_source_o;
      o.ior  = bus.ior_o;
      o.mr   = bus.mem_read_o;
      o.mw   = bus.mem_write_o;
      o.irw  = bus.ir_write_o;
      o.rw   = bus.reg_write_o;
      o.rdst = bus.reg_dst_o;
      o.m2r  = bus.mem_to_reg_o;
      o.sa   = bus.alu_src_a_o;
      o.sb   = bus.alu_src_b_o;
      o.op   = bus.alu_op_o;
      o.zx   = bus.zero_ext_o;
      o.bc   = bus.branch_cond_o;
      return o;
   endfunction

   function automatic tb_ctl_t e_fetch(input logic rdy);
      tb_ctl_t e = '0;
      e.mr = 1'b1; e.sb = 2'd1; e.pw = rdy; e.irw = rdy;
      return e;
   endfunction

   function automatic tb_ctl_t e_decode();
      tb_ctl_t e = '0;
      e.sb = 2'd3;
      return e;
   endfunction

   function automatic tb_ctl_t e_memadr();
      tb_ctl_t e = '0;
      e.sa = 1'b1; e.sb = 2'd2;
      return e;
   endfunction

   function automatic tb_ctl_t e_mem(input logic wr);
      tb_ctl_t e = '0;
      e.ior = 1'b1; e.mr = ~wr; e.mw = wr;
      return e;
   endfunction

   function automatic tb_ctl_t e_memwb();
      tb_ctl_t e = '0;
      e.rw = 1'b1; e.m2r = 2'd1;
      return e;
   endfunction

   function automatic tb_ctl_t e_exec(input logic [3:0] op, input logic [1:0] sb, input logic zx);
      tb_ctl_t e = '0;
      e.sa = 1'b1; e.sb = sb; e.op = op; e.zx = zx;
      return e;
   endfunction

   function automatic tb_ctl_t e_aluwb(input logic [1:0] rdst);
      tb_ctl_t e = '0;
      e.rw = 1'b1; e.rdst = rdst;
      return e;
   endfunction

   function automatic tb_ctl_t e_branch(input logic [1:0] bc);
      tb_ctl_t e = '0;
      e.sa = 1'b1; e.op = 4'd1; e.pwc = 1'b1; e.psrc = 2'd1; e.bc = bc;
      return e;
   endfunction

   function automatic tb_ctl_t e_jump(input logic [1:0] psrc, input logic link);
      tb_ctl_t e = '0;
      e.pw = 1'b1; e.psrc = psrc;
      if (link) begin
         e.rw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2;
      end
      return e;
   endfunction

   task automatic chk_ctl(input string tag, input tb_ctl_t exp);
      tb_ctl_t o;
      o = obs();
      n_total++;
      assert (o === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, o, exp);
   endtask

   task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] exp);
      n_total++;
      assert (o === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, o, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
      bus.opcode_i = op;
      bus.funct_i  = fn;
      #1;
   endtask

   initial begin
      bus.opcode_i       = 6'd0;
      bus.funct_i        = 6'd0;
      bus.mem_ready_i    = 1'b1;
      bus.branch_taken_i = 1'b0;
      #2;
      chk_ctl("reset_strobes", '0);
      chk_val("reset_retired", bus.retired_o, 0);
      chk_val("reset_trap", {31'd0, bus.trap_o}, 0);

      // Fetch stall, then reset mid-handshake
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ready_i = 1'b0;
      #1;
      chk_ctl("fetch_stall", e_fetch(1'b0));
      step();
      chk_ctl("fetch_hold", e_fetch(1'b0));
      #2 rst = 1'b0;
      #1;
      chk_ctl("rst_mid_fetch", '0);
      chk_val("rst_mid_retired", bus.retired_o, 0);
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ready_i = 1'b1;

      // add: 4 cycles
      set_ir(6'd0, 6'd32);
      chk_ctl("add_fetch", e_fetch(1'b1));
      step(); chk_ctl("add_decode", e_decode());
      step();
      set_ir(6'd63, 6'd0);
      chk_ctl("add_exec", e_exec(4'd2, 2'd0, 1'b0));
      step(); chk_ctl("add_aluwb", e_aluwb(2'd1));
      chk_val("add_retired_before", bus.retired_o, 0);
      step(); chk_val("add_retired", bus.retired_o, 1);

      // lw with two wait cycles in MEMRD: 7 cycles
      set_ir(6'd35, 6'd0);
      chk_ctl("lw_fetch", e_fetch(1'b1));
      step(); chk_ctl("lw_decode", e_decode());
      step(); chk_ctl("lw_memadr", e_memadr());
      bus.mem_ready_i = 1'b0;
      step(); chk_ctl("lw_memrd0", e_mem(1'b0));
      step(); chk_ctl("lw_memrd1", e_mem(1'b0));
      bus.mem_ready_i = 1'b1;
      #1;
      chk_ctl("lw_memrd2", e_mem(1'b0));
      step(); chk_ctl("lw_memwb", e_memwb());
      step(); chk_val("lw_retired", bus.retired_o, 2);

      // sw: 4 cycles
      set_ir(6'd43, 6'd0);
      chk_ctl("sw_fetch", e_fetch(1'b1));
      step(); chk_ctl("sw_decode", e_decode());
      step(); chk_ctl("sw_memadr", e_memadr());
      step(); chk_ctl("sw_memwr", e_mem(1'b1));
      step(); chk_val("sw_retired", bus.retired_o, 3);

      // ori: zero-extended OR
      set_ir(6'd13, 6'd0);
      step(); chk_ctl("ori_decode", e_decode());
      step(); chk_ctl("ori_exec", e_exec(4'd3, 2'd2, 1'b1));
      step(); chk_ctl("ori_aluwb", e_aluwb(2'd0));
      step(); chk_val("ori_retired", bus.retired_o, 4);

      // beq not taken, bne taken: 3 cycles each
      set_ir(6'd4, 6'd0);
      bus.branch_taken_i = 1'b0;
      step(); chk_ctl("beq_decode", e_decode());
      step(); chk_ctl("beq_branch", e_branch(2'd0));
      step(); chk_val("beq_retired", bus.retired_o, 5);
      set_ir(6'd5, 6'd0);
      bus.branch_taken_i = 1'b1;
      step(); step(); chk_ctl("bne_branch", e_branch(2'd1));
      step(); chk_val("bne_retired", bus.retired_o, 6);

      // jal then jr
      set_ir(6'd3, 6'd0);
      step(); step(); chk_ctl("jal_jump", e_jump(2'd2, 1'b1));
      step(); chk_val("jal_retired", bus.retired_o, 7);
      set_ir(6'd0, 6'd8);
      step(); step(); chk_ctl("jr_jump", e_jump(2'd3, 1'b0));
      step(); chk_val("jr_retired", bus.retired_o, 8);

      // Illegal opcode: sticky trap until reset
      set_ir(6'd63, 6'd0);
      chk_ctl("trap_fetch", e_fetch(1'b1));
      step(); chk_ctl("trap_decode", e_decode());
      step();
      for (int i = 0; i < 20; i++) begin
         chk_ctl("trap_strobes", '0);
         chk_val("trap_flag", {31'd0, bus.trap_o}, 1);
         step();
      end
      chk_val("trap_retired", bus.retired_o, 8);
      rst = 1'b0;
      #1;
      chk_val("trap_cleared", {31'd0, bus.trap_o}, 0);
      chk_val("trap_rst_retired", bus.retired_o, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_ctl("post_trap_fetch", e_fetch(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
